// File: rtl/round_key_sched_pkg.sv
// Shared types and constants for the round-key schedule controller.
package round_key_sched_pkg;

  localparam int RIDX_W = 4;

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_EXPAND = 2'd2,
    S_READY  = 2'd3
  } ks_state_e;

  // Identity of the requester granted most recently.
  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_gnt_e;

  // GF(2^8) doubling: next round constant.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/round_key_sched_rr_arbiter_2.sv
// Two-way round-robin arbiter with a registered one-hot grant.
// win_a/win_b expose the decision being registered this cycle so the
// owner can capture winner-specific data on the same edge.
module rr_arbiter_2
  import round_key_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic win_a,
  output logic win_b,
  output logic gnt_a,
  output logic gnt_b
);

  last_gnt_e  last_gnt_q, last_gnt_d;
  logic [1:0] gnt_q, gnt_d;

  // Decide the winner: alternate on contention, otherwise serve the lone requester.
  always_comb begin
    gnt_d      = 2'b00;
    last_gnt_d = last_gnt_q;
    if (en) begin
      if (req_a && req_b) begin
        if (last_gnt_q == LAST_B) gnt_d = 2'b01;
        else                      gnt_d = 2'b10;
      end else if (req_a) begin
        gnt_d = 2'b01;
      end else if (req_b) begin
        gnt_d = 2'b10;
      end
    end
    if (gnt_d[0]) last_gnt_d = LAST_A;
    if (gnt_d[1]) last_gnt_d = LAST_B;
  end

  // Grant and priority state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q      <= 2'b00;
      last_gnt_q <= LAST_B;
    end else begin
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  assign win_a = gnt_d[0];
  assign win_b = gnt_d[1];
  assign gnt_a = gnt_q[0];
  assign gnt_b = gnt_q[1];

endmodule

// File: rtl/round_key_sched.sv
// Round-key register file controller: sequences key expansion (LOAD then
// one EXPAND cycle per round), then arbitrates the single read port between
// the cipher and inverse-cipher engines.
module round_key_sched
  import round_key_sched_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ke_load,
  output logic              ke_step,
  output logic [7:0]        rcon,
  output logic              rf_we,
  output logic [RIDX_W-1:0] rf_waddr,
  output logic              keys_ready,
  output logic              busy,
  input  logic              req_a,
  input  logic [RIDX_W-1:0] rd_round_a,
  output logic              gnt_a,
  output logic              err_a,
  input  logic              req_b,
  input  logic [RIDX_W-1:0] rd_round_b,
  output logic              gnt_b,
  output logic              err_b,
  output logic [RIDX_W-1:0] rf_raddr
);

  localparam logic [RIDX_W-1:0] LAST_RND = RIDX_W'(NUM_ROUNDS);

  ks_state_e         state_q, state_d;
  logic [RIDX_W-1:0] round_q, round_d;
  logic [7:0]        rcon_q, rcon_d;
  logic              keys_ready_q, keys_ready_d;
  logic [RIDX_W-1:0] raddr_q, raddr_d;
  logic              err_a_q, err_a_d;
  logic              err_b_q, err_b_d;
  logic              arb_en;
  logic              win_a, win_b;

  // Expansion sequencer: next state, round counter and round constant.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          rcon_d  = RCON_INIT;
        end
      end
      S_LOAD: begin
        state_d = S_EXPAND;
        round_d = {{(RIDX_W-1){1'b0}}, 1'b1};
        rcon_d  = RCON_INIT;
      end
      S_EXPAND: begin
        rcon_d = xtime(rcon_q);
        if (round_q == LAST_RND) begin
          state_d = S_READY;
          round_d = '0;
        end else begin
          round_d = round_q + 1'b1;
        end
      end
      S_READY: begin
        if (start) begin
          state_d = S_LOAD;
          rcon_d  = RCON_INIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // keys_ready follows READY by one cycle; reads open only once it is high,
  // and a restart drops it on the same edge that leaves READY.
  always_comb begin
    keys_ready_d = (state_q == S_READY) && !start;
    arb_en       = keys_ready_q && !start;
  end

  rr_arbiter_2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .req_a (req_a),
    .req_b (req_b),
    .win_a (win_a),
    .win_b (win_b),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  // Read select and error flags captured alongside the grant; out-of-range
  // rounds select entry 0.
  always_comb begin
    raddr_d = raddr_q;
    err_a_d = 1'b0;
    err_b_d = 1'b0;
    if (win_a) begin
      err_a_d = (rd_round_a > LAST_RND);
      raddr_d = err_a_d ? '0 : rd_round_a;
    end else if (win_b) begin
      err_b_d = (rd_round_b > LAST_RND);
      raddr_d = err_b_d ? '0 : rd_round_b;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      round_q      <= '0;
      rcon_q       <= RCON_INIT;
      keys_ready_q <= 1'b0;
      raddr_q      <= '0;
      err_a_q      <= 1'b0;
      err_b_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      rcon_q       <= rcon_d;
      keys_ready_q <= keys_ready_d;
      raddr_q      <= raddr_d;
      err_a_q      <= err_a_d;
      err_b_q      <= err_b_d;
    end
  end

  // Datapath strobes decoded from registered state only.
  always_comb begin
    ke_load  = (state_q == S_LOAD);
    ke_step  = (state_q == S_EXPAND);
    rf_we    = ke_load || ke_step;
    busy     = rf_we;
    rf_waddr = ke_step ? round_q : '0;
    rcon     = rcon_q;
  end

  assign keys_ready = keys_ready_q;
  assign rf_raddr   = raddr_q;
  assign err_a      = err_a_q;
  assign err_b      = err_b_q;

endmodule

// File: tb/tb_round_key_sched.sv
// Scoreboard bench: stimulus pushes expected writes/grants, negedge monitors
// pop and compare whenever the DUT writes or grants.
module tb_round_key_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0;

  logic start0 = 0, ra0 = 0, rb0 = 0;
  logic [3:0] rda0 = 0, rdb0 = 0;
  logic ld0, st0, we0, kr0, bz0, ga0, ea0, gb0, eb0;
  logic [7:0] rc0;
  logic [3:0] wa0, rr0;

  logic start1 = 0, ra1 = 0, rb1 = 0;
  logic [3:0] rda1 = 0, rdb1 = 0;
  logic ld1, st1, we1, kr1, bz1, ga1, ea1, gb1, eb1;
  logic [7:0] rc1;
  logic [3:0] wa1, rr1;

  round_key_sched #(.NUM_ROUNDS(10)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .ke_load(ld0), .ke_step(st0),
    .rcon(rc0), .rf_we(we0), .rf_waddr(wa0), .keys_ready(kr0), .busy(bz0),
    .req_a(ra0), .rd_round_a(rda0), .gnt_a(ga0), .err_a(ea0),
    .req_b(rb0), .rd_round_b(rdb0), .gnt_b(gb0), .err_b(eb0), .rf_raddr(rr0));

  round_key_sched #(.NUM_ROUNDS(14)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .ke_load(ld1), .ke_step(st1),
    .rcon(rc1), .rf_we(we1), .rf_waddr(wa1), .keys_ready(kr1), .busy(bz1),
    .req_a(ra1), .rd_round_a(rda1), .gnt_a(ga1), .err_a(ea1),
    .req_b(rb1), .rd_round_b(rdb1), .gnt_b(gb1), .err_b(eb1), .rf_raddr(rr1));

  typedef struct packed {logic ld, st, bz; logic [3:0] a; logic [7:0] rc;} wr_t;
  typedef struct packed {logic ga, gb, ea, eb; logic [3:0] ra;} gr_t;

  wr_t wq0[$], wq1[$];
  gr_t gq0[$], gq1[$];
  logic [7:0] rct [0:14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                             8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A};

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected writes: LOAD at address 0, then rounds 1..n with the rcon table.
  task automatic push_exp(input int d, input int n);
    wr_t w;
    w = '{ld: 1'b1, st: 1'b0, bz: 1'b1, a: 4'd0, rc: 8'h01};
    if (d == 0) wq0.push_back(w); else wq1.push_back(w);
    for (int r = 1; r <= n; r++) begin
      w = '{ld: 1'b0, st: 1'b1, bz: 1'b1, a: 4'(r), rc: rct[r-1]};
      if (d == 0) wq0.push_back(w); else wq1.push_back(w);
    end
  endtask

  function automatic gr_t g(input logic a, input logic b, input logic e, input logic [3:0] ra);
    return '{ga: a, gb: b, ea: a & e, eb: b & e, ra: ra};
  endfunction

  // Monitors: write port of each DUT.
  always @(negedge clk) begin
    if (we0) begin
      if (wq0.size() == 0) chk("wr0_unexpected", 64'(wa0), 64'hFF);
      else chk("wr0", 64'({ld0, st0, bz0, wa0, rc0}), 64'(wq0.pop_front()));
    end
    if (we1) begin
      if (wq1.size() == 0) chk("wr1_unexpected", 64'(wa1), 64'hFF);
      else chk("wr1", 64'({ld1, st1, bz1, wa1, rc1}), 64'(wq1.pop_front()));
    end
  end

  // Monitors: grant port of each DUT.
  always @(negedge clk) begin
    if (ga0 || gb0) begin
      if (gq0.size() == 0) chk("gnt0_unexpected", 64'({ga0, gb0}), 64'hFF);
      else chk("gnt0", 64'({ga0, gb0, ea0, eb0, rr0}), 64'(gq0.pop_front()));
    end
    if (ga1 || gb1) begin
      if (gq1.size() == 0) chk("gnt1_unexpected", 64'({ga1, gb1}), 64'hFF);
      else chk("gnt1", 64'({ga1, gb1, ea1, eb1, rr1}), 64'(gq1.pop_front()));
    end
  end

  task automatic wait_kr0(input int exp_n, input string nm);
    int n = 0;
    while (!kr0 && n < 40) begin tick(); n++; end
    chk(nm, 64'(n), 64'(exp_n));
  endtask

  initial begin
    int n;
    #1 rst = 1'b1;
    #2;
    chk("rst_outs0", 64'({ld0, st0, we0, kr0, bz0, ga0, gb0, ea0, eb0, wa0, rr0, rc0}),
        64'({9'b0, 4'd0, 4'd0, 8'h01}));
    chk("rst_outs1", 64'({ld1, st1, we1, kr1, bz1, ga1, gb1, ea1, eb1, wa1, rr1, rc1}),
        64'({9'b0, 4'd0, 4'd0, 8'h01}));
    tick(); tick();
    rst = 1'b0;
    tick();

    // Full expansion, NUM_ROUNDS=10: keys_ready 12 edges after the start edge.
    push_exp(0, 10);
    start0 = 1; tick(); start0 = 0;
    wait_kr0(12, "kr_latency10");
    chk("wr0_drained", 64'(wq0.size()), 64'd0);

    // Lone request from A.
    ra0 = 1; rda0 = 4'd3; gq0.push_back(g(1, 0, 0, 4'd3));
    tick();
    chk("gnt_a_latency", 64'(ga0), 64'd1);
    ra0 = 0;
    tick(); tick();
    chk("raddr_hold", 64'({ga0, gb0, rr0}), 64'({2'b00, 4'd3}));

    // Both held: last grant was A, so B then A alternating.
    ra0 = 1; rda0 = 4'd5; rb0 = 1; rdb0 = 4'd9;
    gq0.push_back(g(0, 1, 0, 4'd9)); gq0.push_back(g(1, 0, 0, 4'd5));
    gq0.push_back(g(0, 1, 0, 4'd9)); gq0.push_back(g(1, 0, 0, 4'd5));
    repeat (4) tick();
    ra0 = 0; rb0 = 0;
    tick();

    // B out of range: error, select 0.
    rb0 = 1; rdb0 = 4'd12; gq0.push_back(g(0, 1, 1, 4'd0));
    tick(); rb0 = 0; tick();
    chk("err_clear", 64'({gb0, eb0, rr0}), 64'd0);

    // A exactly at the last round: legal.
    ra0 = 1; rda0 = 4'd10; gq0.push_back(g(1, 0, 0, 4'd10));
    tick(); ra0 = 0; tick();

    // Restart from READY, ignore start mid-expansion, reset at round 6.
    push_exp(0, 5);
    start0 = 1; tick(); start0 = 0;
    chk("kr_clear_on_start", 64'(kr0), 64'd0);
    repeat (4) tick();
    start0 = 1; tick(); start0 = 0;
    tick();
    chk("round6_shown", 64'({st0, wa0}), 64'({1'b1, 4'd6}));
    rst = 1'b1;
    #1;
    chk("rst_mid", 64'({ld0, st0, we0, kr0, bz0, ga0, gb0, ea0, eb0, wa0, rr0, rc0}),
        64'({9'b0, 4'd0, 4'd0, 8'h01}));
    tick();
    rst = 1'b0;
    chk("abort_drained", 64'(wq0.size()), 64'd0);
    tick();
    push_exp(0, 10);
    start0 = 1; tick(); start0 = 0;
    wait_kr0(12, "kr_latency_reexp");

    // NUM_ROUNDS=14 with A requesting during expansion.
    push_exp(1, 14);
    start1 = 1; tick(); start1 = 0;
    repeat (3) tick();
    ra1 = 1; rda1 = 4'd7; gq1.push_back(g(1, 0, 0, 4'd7));
    n = 3;
    while (!kr1 && n < 40) begin tick(); n++; end
    chk("kr_latency14", 64'(n), 64'd16);
    chk("no_gnt_with_kr_rise", 64'(ga1), 64'd0);
    tick();
    chk("gnt_after_kr", 64'(ga1), 64'd1);
    ra1 = 0;
    tick(); tick();

    chk("wq1_drained", 64'(wq1.size()), 64'd0);
    chk("gq0_drained", 64'(gq0.size()), 64'd0);
    chk("gq1_drained", 64'(gq1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
